mem_protocol_checker: RTL and testbench

Synthesisable, parametrised protocol checker and scoreboard for the single-port memory valid/ready interface. It passively snoops `wr_rd`/`valid`/`ready`/`addr`/`wdata`/`rdata` and checks fixed-latency handshakes and address range. A shadow copy of written data verifies read-back values. It reports sticky error flags, a per-cycle error pulse and saturating transfer/error counters, for use in simulation benches and in FPGA bring-up.

---
 rtl/mem_protocol_checker.sv | 125 ++++++++++++
 tb/tb_mem_protocol_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_protocol_checker.sv
// mem_protocol_checker
// Passive checker and scoreboard for a single-port valid/ready memory
// interface. Each sampled request enters a LAT-deep pipeline. When it
// reaches the head, it must see ready=1 on that edge. A shadow copy of
// written data verifies read-back values. Errors are reported as sticky
// flags, a one-cycle pulse and saturating counters.
module mem_protocol_checker #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int LAT        = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_rd,
    input  logic                  valid,
    input  logic                  ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    output logic [3:0]            err_flags,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH:0]  CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    typedef struct packed {
        logic                  busy;
        logic                  wr;
        logic                  in_range;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } slot_t;

    slot_t                 pipe [LAT];
    slot_t                 issue;
    slot_t                 head;
    logic [WIDTH-1:0]      shadow_data [DEPTH];
    logic [DEPTH-1:0]      shadow_valid;
    logic [IDX_W-1:0]      head_idx;
    logic                  complete;
    logic                  hs_miss;
    logic                  hs_spur;
    logic                  addr_range;
    logic                  data_mismatch;
    logic [3:0]            new_err;
    logic [1:0]            n_err;

    // Add a small error count to a counter and clamp at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, base} + (CNT_WIDTH + 1)'(inc);
        return (sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
    endfunction

    // Build the pipeline entry for this edge and decode all error conditions.
    always_comb begin
        issue.busy     = valid;
        issue.wr       = wr_rd;
        issue.in_range = ({1'b0, addr} < DEPTH_W);
        issue.addr     = addr;
        issue.data     = wdata;
        head           = pipe[LAT-1];
        head_idx       = head.addr[IDX_W-1:0];
        complete       = head.busy & ready;
        hs_miss        = head.busy & ~ready;
        hs_spur        = ~head.busy & ready;
        addr_range     = valid & ~issue.in_range;
        data_mismatch  = complete & ~head.wr & head.in_range & shadow_valid[head_idx]
                         & (rdata != shadow_data[head_idx]);
        new_err        = {data_mismatch, addr_range, hs_spur, hs_miss};
        n_err          = {1'b0, hs_miss} + {1'b0, hs_spur} + {1'b0, addr_range}
                         + {1'b0, data_mismatch};
    end

    // Shift requests (or bubbles) towards the head, one stage per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Shadow data is only meaningful where its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (complete && head.wr && head.in_range) shadow_data[head_idx] <= head.data;
    end

    // Mark addresses that have received a completed in-range write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_valid <= '0;
        end else if (complete && head.wr && head.in_range) begin
            shadow_valid[head_idx] <= 1'b1;
        end
    end

    // Sticky flags, error pulse and saturating counters. Events on a clr edge are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            err_flags <= (clr ? 4'b0000 : err_flags) | new_err;
            err_pulse <= (n_err != 2'd0);
            wr_count  <= sat_add(clr ? '0 : wr_count, {1'b0, complete & head.wr});
            rd_count  <= sat_add(clr ? '0 : rd_count, {1'b0, complete & ~head.wr});
            err_count <= sat_add(clr ? '0 : err_count, n_err);
        end
    end

endmodule

// File: tb/tb_mem_protocol_checker.sv
// Testbench for mem_protocol_checker: directed scenarios followed by random
// traffic, all checked against a transaction-level model. The model keeps
// a queue of outstanding requests tagged with their due edge and a shadow
// memory.
module tb_mem_protocol_checker;

   localparam int AW = 6;
   localparam int W  = 8;
   localparam int D  = 40;
   localparam int L  = 2;
   localparam int CW = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          clr;
   logic          wrRd;
   logic          valid;
   logic          ready;
   logic [AW-1:0] addr;
   logic [W-1:0]  wdata;
   logic [W-1:0]  rdata;
   logic [3:0]    errFlags;
   logic          errPulse;
   logic [CW-1:0] wrCount;
   logic [CW-1:0] rdCount;
   logic [CW-1:0] errCount;

   mem_protocol_checker #(
      .ADDR_WIDTH(AW), .WIDTH(W), .DEPTH(D), .LAT(L), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_rd(wrRd), .valid(valid), .ready(ready),
      .addr(addr), .wdata(wdata), .rdata(rdata), .err_flags(errFlags),
      .err_pulse(errPulse), .wr_count(wrCount), .rd_count(rdCount), .err_count(errCount)
   );

   typedef struct {
      bit       wr;
      int       a;
      bit [W-1:0] d;
      int       due;
   } req_t;

   req_t      pending[$];
   bit [W-1:0] shData[D];
   bit        shValid[D];
   bit [3:0]  mFlags;
   int        mPulse, mWr, mRd, mErr;
   int        edgeNo;
   int        checks;
   int        errors;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int satAdd(input int base, input int inc);
      return (base + inc > CMAX) ? CMAX : base + inc;
   endfunction

   function automatic bit headDue();
      return pending.size() > 0 && pending[0].due == edgeNo;
   endfunction

   task automatic checkAll(input string tag);
      checkOutput({tag, ".flags"}, int'(errFlags), int'(mFlags));
      checkOutput({tag, ".pulse"}, int'(errPulse), mPulse);
      checkOutput({tag, ".wr"}, int'(wrCount), mWr);
      checkOutput({tag, ".rd"}, int'(rdCount), mRd);
      checkOutput({tag, ".err"}, int'(errCount), mErr);
   endtask

   // Drive one cycle of inputs, advance the model by one edge, then compare
   task automatic applyStimulus(input bit v, input bit wr, input int a, input bit [W-1:0] d,
                                input bit rdy, input bit [W-1:0] rd, input bit c,
                                input string tag);
      bit [3:0] newErr;
      int       incW, incR, nErr;
      req_t     h, r;
      valid = v; wrRd = wr; addr = AW'(a); wdata = d; ready = rdy; rdata = rd; clr = c;
      newErr = '0; incW = 0; incR = 0;
      if (headDue()) begin
         h = pending.pop_front();
         if (rdy) begin
            if (h.wr) begin
               incW = 1;
               if (h.a < D) begin
                  shData[h.a] = h.d;
                  shValid[h.a] = 1'b1;
               end
            end else begin
               incR = 1;
               if (h.a < D && shValid[h.a] && rd != shData[h.a]) newErr[3] = 1'b1;
            end
         end else begin
            newErr[0] = 1'b1;
         end
      end else if (rdy) begin
         newErr[1] = 1'b1;
      end
      if (v) begin
         if (a >= D) newErr[2] = 1'b1;
         r.wr = wr; r.a = a; r.d = d; r.due = edgeNo + L;
         pending.push_back(r);
      end
      nErr   = int'(newErr[0]) + int'(newErr[1]) + int'(newErr[2]) + int'(newErr[3]);
      mFlags = (c ? 4'b0000 : mFlags) | newErr;
      mPulse = (nErr > 0) ? 1 : 0;
      mWr    = satAdd(c ? 0 : mWr, incW);
      mRd    = satAdd(c ? 0 : mRd, incR);
      mErr   = satAdd(c ? 0 : mErr, nErr);
      @(posedge clk);
      edgeNo++;
      #1;
      checkAll(tag);
   endtask

   task automatic idle(input bit rdy, input bit [W-1:0] rd, input string tag);
      applyStimulus(1'b0, 1'b0, 0, '0, rdy, rd, 1'b0, tag);
   endtask

   // Asynchronous reset asserted mid-cycle with random inputs
   task automatic doReset();
      #3;
      valid = 1'($urandom); wrRd = 1'($urandom); addr = AW'($urandom); wdata = W'($urandom);
      ready = 1'($urandom); rdata = W'($urandom); clr = 1'($urandom);
      rst = 1'b1;
      #1;
      checkOutput("rst.flags", int'(errFlags), 0);
      checkOutput("rst.pulse", int'(errPulse), 0);
      checkOutput("rst.wr", int'(wrCount), 0);
      checkOutput("rst.rd", int'(rdCount), 0);
      checkOutput("rst.err", int'(errCount), 0);
      pending.delete();
      for (int i = 0; i < D; i++) shValid[i] = 1'b0;
      mFlags = '0; mPulse = 0; mWr = 0; mRd = 0; mErr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      valid = 1'b0; ready = 1'b0; clr = 1'b0;
      #1;
      checkOutput("rstrel.flags", int'(errFlags), 0);
      checkOutput("rstrel.err", int'(errCount), 0);
   endtask

   // Main sequence: directed scenarios, then random traffic
   initial begin
      bit         v, wr, rdy, c;
      int         a;
      bit [W-1:0] d, rd;
      checks = 0; errors = 0; edgeNo = 0;
      rst = 1'b1; clr = 1'b0; valid = 1'b0; wrRd = 1'b0; ready = 1'b0;
      addr = '0; wdata = '0; rdata = '0;
      #12;
      doReset();

      // Write then read back the same address with the right data
      applyStimulus(1'b1, 1'b1, 31, 8'd226, 1'b0, '0, 1'b0, "wr31");
      idle(1'b0, '0, "wr31.wait");
      idle(1'b1, '0, "wr31.done");
      applyStimulus(1'b1, 1'b0, 31, '0, 1'b0, '0, 1'b0, "rd31");
      idle(1'b0, '0, "rd31.wait");
      idle(1'b1, 8'd226, "rd31.done");
      checkOutput("pass.wr", int'(wrCount), 1);
      checkOutput("pass.rd", int'(rdCount), 1);
      checkOutput("pass.flags", int'(errFlags), 0);

      // Read back with corrupted data, then clear
      applyStimulus(1'b1, 1'b0, 31, '0, 1'b0, '0, 1'b0, "mis");
      idle(1'b0, '0, "mis.wait");
      idle(1'b1, 8'd225, "mis.done");
      checkOutput("mis.flags", int'(errFlags), 8);
      checkOutput("mis.err", int'(errCount), 1);
      idle(1'b0, '0, "mis.after");
      checkOutput("mis.pulseGone", int'(errPulse), 0);
      applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, '0, 1'b1, "clr1");
      checkOutput("clr1.flags", int'(errFlags), 0);
      checkOutput("clr1.rd", int'(rdCount), 0);

      // Missing ready, then spurious ready
      applyStimulus(1'b1, 1'b1, 3, 8'd55, 1'b0, '0, 1'b0, "miss");
      idle(1'b0, '0, "miss.wait");
      idle(1'b0, '0, "miss.drop");
      checkOutput("miss.flags", int'(errFlags), 1);
      checkOutput("miss.wr", int'(wrCount), 0);
      idle(1'b1, '0, "spur");
      checkOutput("spur.flags", int'(errFlags), 3);
      checkOutput("spur.err", int'(errCount), 2);
      applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, '0, 1'b1, "clr2");

      // Out-of-range write and read: counted but never compared
      applyStimulus(1'b1, 1'b1, 45, 8'd7, 1'b0, '0, 1'b0, "rngw");
      idle(1'b0, '0, "rngw.wait");
      idle(1'b1, '0, "rngw.done");
      applyStimulus(1'b1, 1'b0, 45, '0, 1'b0, '0, 1'b0, "rngr");
      idle(1'b0, '0, "rngr.wait");
      idle(1'b1, 8'd99, "rngr.done");
      checkOutput("rng.flags", int'(errFlags), 4);
      checkOutput("rng.err", int'(errCount), 2);
      checkOutput("rng.wr", int'(wrCount), 1);
      checkOutput("rng.rd", int'(rdCount), 1);

      // Reset while a write is in flight: the later read is unchecked
      applyStimulus(1'b1, 1'b1, 5, 8'd9, 1'b0, '0, 1'b0, "mid.wr");
      doReset();
      applyStimulus(1'b1, 1'b0, 5, '0, 1'b0, '0, 1'b0, "mid.rd");
      idle(1'b0, '0, "mid.wait");
      idle(1'b1, 8'd0, "mid.done");
      checkOutput("mid.flags", int'(errFlags), 0);

      // Back-to-back legal writes saturate the write counter
      for (int i = 0; i < 40; i++)
         applyStimulus(1'b1, 1'b1, i % D, W'(i), headDue(), '0, 1'b0, "sat");
      idle(headDue(), '0, "sat.f1");
      idle(headDue(), '0, "sat.f2");
      checkOutput("sat.wr", int'(wrCount), CMAX);
      checkOutput("sat.flags", int'(errFlags), 0);

      // Random traffic with occasional protocol faults, clears and resets
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(299) == 0) doReset();
         v   = 1'($urandom);
         wr  = 1'($urandom);
         a   = ($urandom_range(7) == 0) ? int'($urandom_range(63)) : int'($urandom_range(7));
         d   = W'($urandom);
         rdy = headDue();
         if ($urandom_range(19) == 0) rdy = !rdy;
         rd  = W'($urandom);
         if (headDue() && !pending[0].wr && pending[0].a < D && $urandom_range(7) != 0)
            rd = shData[pending[0].a];
         c   = ($urandom_range(49) == 0);
         applyStimulus(v, wr, a, d, rdy, rd, c, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
